// File: rtl/waveform_sequencer.sv
// Plays a combinationally read waveform memory, holding each element per_q cycles before offering it.
// First valid per_q cycles after start; backpressure stretches EMIT only, and the timer is frozen there.
module waveform_sequencer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int PER_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wave_ready,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [PER_W-1:0]  period,
  input  logic [ADDR_W:0]   wave_len,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              wrap_pulse,
  output logic              done
);
  typedef enum logic [1:0] {S_IDLE, S_TICK, S_EMIT, S_DONE} state_t;

  localparam int LW = ADDR_W + 1;
  localparam logic [ADDR_W:0]  LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]  LEN_ONE = LW'(1);
  localparam logic [PER_W-1:0] PER_ONE = PER_W'(1);

  state_t            r_state, w_state_nxt;
  logic [PER_W-1:0]  r_per_q, w_per_nxt, w_per_in;
  logic [PER_W-1:0]  r_timer, w_timer_nxt;
  logic [ADDR_W:0]   r_len_q, w_len_nxt, w_len_in;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_sample, w_sample_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_done, w_done_nxt;
  logic              w_busy, w_abort, w_hs, w_last, w_wrap;

  always_comb begin
    w_busy   = (r_state == S_TICK) || (r_state == S_EMIT);
    w_abort  = stop || (w_busy && !wave_ready);
    w_hs     = (r_state == S_EMIT) && r_valid && sample_ready;
    w_last   = ({1'b0, r_addr} == (r_len_q - LEN_ONE));
    w_per_in = (period == '0) ? PER_ONE : period;
    w_len_in = ((wave_len == '0) || (wave_len > LEN_MAX)) ? LEN_MAX : wave_len;

    w_state_nxt  = r_state;
    w_per_nxt    = r_per_q;
    w_len_nxt    = r_len_q;
    w_timer_nxt  = r_timer;
    w_addr_nxt   = r_addr;
    w_sample_nxt = r_sample;
    w_valid_nxt  = r_valid;
    w_done_nxt   = r_done;
    w_wrap       = 1'b0;

    // Abort wins over everything, including a handshake in the same cycle.
    if (w_abort) begin
      w_state_nxt = S_IDLE;
      w_valid_nxt = 1'b0;
      w_done_nxt  = 1'b0;
      w_addr_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start && wave_ready) begin
            w_per_nxt   = w_per_in;
            w_len_nxt   = w_len_in;
            w_addr_nxt  = '0;
            w_timer_nxt = w_per_in - PER_ONE;
            w_done_nxt  = 1'b0;
            w_state_nxt = S_TICK;
          end
        end
        S_TICK: begin
          if (r_timer != '0) begin
            w_timer_nxt = r_timer - PER_ONE;
          end else begin
            w_sample_nxt = rd_data;
            w_valid_nxt  = 1'b1;
            w_state_nxt  = S_EMIT;
          end
        end
        S_EMIT: begin
          if (w_hs) begin
            w_valid_nxt = 1'b0;
            if (!w_last) begin
              w_addr_nxt  = r_addr + 1'b1;
              w_timer_nxt = r_per_q - PER_ONE;
              w_state_nxt = S_TICK;
            end else begin
              w_wrap = 1'b1;
              if (loop_en) begin
                w_addr_nxt  = '0;
                w_timer_nxt = r_per_q - PER_ONE;
                w_state_nxt = S_TICK;
              end else begin
                w_done_nxt  = 1'b1;
                w_state_nxt = S_DONE;
              end
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_per_q  <= '0;
      r_len_q  <= '0;
      r_timer  <= '0;
      r_addr   <= '0;
      r_sample <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_per_q  <= w_per_nxt;
      r_len_q  <= w_len_nxt;
      r_timer  <= w_timer_nxt;
      r_addr   <= w_addr_nxt;
      r_sample <= w_sample_nxt;
      r_valid  <= w_valid_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign rd_addr      = r_addr;
  assign sample_out   = r_sample;
  assign sample_valid = r_valid;
  assign busy         = w_busy;
  assign wrap_pulse   = w_wrap;
  assign done         = r_done;

endmodule

// File: tb/tb_waveform_sequencer.sv
// Bench for waveform_sequencer: vector table of runs plus hand-written stall/abort/reset sequences.
module tb_waveform_sequencer;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int PER_W  = 16;

  logic              clk = 1'b0;
  logic              reset_n, wave_ready, start, stop, loop_en, sample_ready;
  logic [PER_W-1:0]  period;
  logic [ADDR_W:0]   wave_len;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data, sample_out;
  logic              sample_valid, busy, wrap_pulse, done;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              last;
    int                cyc;
  } exp_t;

  typedef struct {
    logic [PER_W-1:0] period;
    logic [ADDR_W:0]  wave_len;
    logic             loop_en;
    int               n;
    int               eff_per;
    int               eff_len;
    logic             exp_done;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[5];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  waveform_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PER_W(PER_W)) dut (
    .clk(clk), .reset_n(reset_n), .wave_ready(wave_ready), .start(start), .stop(stop),
    .loop_en(loop_en), .period(period), .wave_len(wave_len), .rd_addr(rd_addr),
    .rd_data(rd_data), .sample_out(sample_out), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .busy(busy), .wrap_pulse(wrap_pulse), .done(done)
  );

  // Memory holds mem[i] = i+1.
  assign rd_data = DATA_W'(rd_addr) + 32'd1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int a, input int last, input int c);
    exp_t e;
    e.data = DATA_W'(a + 1);
    e.addr = ADDR_W'(a);
    e.last = (last != 0);
    e.cyc  = c;
    sb_q.push_back(e);
  endtask

  // Handshake monitor: every accepted sample must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (sample_valid && sample_ready) begin
        check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          check("sample_data", 64'(sample_out), 64'(mon_e.data));
          check("rd_addr", 64'(rd_addr), 64'(mon_e.addr));
          check("wrap_pulse", 64'(wrap_pulse), 64'(mon_e.last));
          if (mon_e.cyc >= 0) check("valid_cycle", 64'(cyc), 64'(mon_e.cyc));
        end
      end else begin
        check("wrap_idle", 64'(wrap_pulse), 64'd0);
      end
    end
  end

  task automatic wait_valid(input string name, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sample_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 64'(ok), 64'd1);
  endtask

  // Returns #1 after the clock edge that completed the last expected handshake.
  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) @(posedge clk);
    check(name, 64'(sb_q.size()), 64'd0);
    sb_q.delete();
    #1;
  endtask

  task automatic pulse_stop();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_busy", 64'(busy), 64'd0);
    check("stop_done", 64'(done), 64'd0);
    check("stop_addr", 64'(rd_addr), 64'd0);
  endtask

  task automatic run_vector(input vec_t v);
    int s, a;
    @(negedge clk);
    period       = v.period;
    wave_len     = v.wave_len;
    loop_en      = v.loop_en;
    sample_ready = 1'b1;
    start        = 1'b1;
    s = cyc + 1;
    for (int k = 0; k < v.n; k++) begin
      a = k % v.eff_len;
      push(a, int'(a == v.eff_len - 1), s + v.eff_per + k * (v.eff_per + 1));
    end
    @(negedge clk);
    start = 1'b0;
    drain("vec_drain", 6000);
    sample_ready = 1'b0;
    @(negedge clk);
    check("vec_done", 64'(done), 64'(v.exp_done));
    check("vec_busy", 64'(busy), 64'(!v.exp_done));
    if (v.exp_done) begin
      repeat (3) @(negedge clk);
      check("vec_done_held", 64'(done), 64'd1);
    end
    pulse_stop();
  endtask

  initial begin
    int a0;
    vecs[0] = '{period: 16'd3, wave_len: 11'd4,    loop_en: 1'b0, n: 4,    eff_per: 3, eff_len: 4,    exp_done: 1'b1};
    vecs[1] = '{period: 16'd3, wave_len: 11'd4,    loop_en: 1'b1, n: 6,    eff_per: 3, eff_len: 4,    exp_done: 1'b0};
    vecs[2] = '{period: 16'd0, wave_len: 11'd0,    loop_en: 1'b0, n: 1024, eff_per: 1, eff_len: 1024, exp_done: 1'b1};
    vecs[3] = '{period: 16'd2, wave_len: 11'd1,    loop_en: 1'b1, n: 3,    eff_per: 2, eff_len: 1,    exp_done: 1'b0};
    vecs[4] = '{period: 16'd1, wave_len: 11'd1025, loop_en: 1'b1, n: 1026, eff_per: 1, eff_len: 1024, exp_done: 1'b0};

    reset_n = 1'b1; wave_ready = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    sample_ready = 1'b0; period = '0; wave_len = '0;
    #1 reset_n = 1'b0;
    #1;
    check("rst_addr", 64'(rd_addr), 64'd0);
    check("rst_sample", 64'(sample_out), 64'd0);
    check("rst_valid", 64'(sample_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_wrap", 64'(wrap_pulse), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 5; i++) run_vector(vecs[i]);

    // Backpressure on the 2nd sample, period 1, length 4, one-shot.
    @(negedge clk);
    period = 16'd1; wave_len = 11'd4; loop_en = 1'b0; sample_ready = 1'b0; start = 1'b1;
    push(0, 0, -1);
    push(1, 0, -1);
    @(negedge clk);
    start = 1'b0;
    wait_valid("t3_first_valid", 20);
    @(posedge clk); #1 sample_ready = 1'b1;
    @(posedge clk); #1 sample_ready = 1'b0;
    wait_valid("t3_second_valid", 20);
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_data", 64'(sample_out), 64'd2);
      check("t3_hold_valid", 64'(sample_valid), 64'd1);
      check("t3_hold_addr", 64'(rd_addr), 64'd1);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1 sample_ready = 1'b1;
    a0 = cyc;
    push(2, 0, a0 + 2);
    push(3, 1, a0 + 4);
    @(negedge clk);
    @(negedge clk);
    check("t3_gap_valid", 64'(sample_valid), 64'd0);
    drain("t3_drain", 50);
    @(negedge clk);
    check("t3_done", 64'(done), 64'd1);

    // Stop while EMIT is stalled, then restart from element 0 (start from DONE).
    @(posedge clk); #1 sample_ready = 1'b0;
    @(negedge clk);
    period = 16'd2; wave_len = 11'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t4_done_clr", 64'(done), 64'd0);
    wait_valid("t4_valid", 20);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("t4_valid_drop", 64'(sample_valid), 64'd0);
    check("t4_busy", 64'(busy), 64'd0);
    check("t4_addr", 64'(rd_addr), 64'd0);
    @(posedge clk); #1 sample_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    push(0, 0, cyc + 1 + 2);
    @(negedge clk);
    start = 1'b0;
    drain("t4_restart", 50);
    sample_ready = 1'b0;
    pulse_stop();

    // Memory reload mid-run aborts; start while not ready is ignored.
    @(negedge clk);
    period = 16'd2; wave_len = 11'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5_busy_run", 64'(busy), 64'd1);
    wave_ready = 1'b0;
    @(negedge clk);
    check("t5_abort_busy", 64'(busy), 64'd0);
    check("t5_abort_valid", 64'(sample_valid), 64'd0);
    check("t5_abort_addr", 64'(rd_addr), 64'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("t5_start_ignored", 64'(busy), 64'd0);
    wave_ready = 1'b1;

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    period = 16'd1; wave_len = 11'd4; loop_en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid("t6_valid", 20);
    check("t6_pre_sample", 64'(sample_out), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_sample", 64'(sample_out), 64'd0);
    check("t6_valid", 64'(sample_valid), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_addr", 64'(rd_addr), 64'd0);
    check("t6_done", 64'(done), 64'd0);
    check("t6_wrap", 64'(wrap_pulse), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
